// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: per-cycle load/hold/bubble control for PC, IF/ID and ID/EX
// covering load-use stalls, EX-resolved redirects and fixed-latency multi-cycle ops.
`default_nettype none

module hazard_stall_controller #(
  parameter int MULTI_LATENCY = 4,
  parameter int CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       MemReadExecute,
  input  logic [4:0]       WriteRegExecute,
  input  logic [4:0]       RsDecode,
  input  logic [4:0]       RtDecode,
  input  logic             UsesRtDecode,
  input  logic             RedirectExecute,
  input  logic             MultiStartExecute,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             MultiBusy,
  output logic             MultiDone,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  localparam logic [7:0]       CNT_LOAD  = 8'(MULTI_LATENCY - 2);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic [7:0] next_cnt;
  logic       load_use;

  assign load_use = (MemReadExecute != 2'b00) && (WriteRegExecute != 5'd0) &&
                    ((WriteRegExecute == RsDecode) ||
                     (UsesRtDecode && (WriteRegExecute == RtDecode)));

  // Outputs are forced low while Reset is held, independent of the async flops.
  always_comb begin
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXWrite  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    MultiBusy  = 1'b0;
    MultiDone  = 1'b0;
    next_state = state;
    next_cnt   = cnt;
    if (!Reset) begin
      case (state)
        RUN: begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
          IDEXWrite = 1'b1;
          if (RedirectExecute) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
          end else if (MultiStartExecute) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
            next_cnt   = CNT_LOAD;
            next_state = MULTI;
          end else if (load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end
        end
        MULTI: begin
          MultiBusy = 1'b1;
          if (cnt != 8'd0) begin
            EXMEMFlush = 1'b1;
            next_cnt   = cnt - 8'd1;
          end else begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXWrite  = 1'b1;
            MultiDone  = 1'b1;
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= RUN;
      cnt        <= 8'd0;
      StallCount <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (!PCWrite && (StallCount != STALL_MAX)) begin
        StallCount <= StallCount + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// Randomized self-checking bench: two instances (latency 4 / 16-bit count, latency 2 / 4-bit count)
// compared each cycle against an occupancy-based reference model.
`default_nettype none

module tb_hazard_stall_controller;

  localparam int LAT_A = 4;
  localparam int CW_A  = 16;
  localparam int LAT_B = 2;
  localparam int CW_B  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mr;
  logic [4:0] wr, rs, rt;
  logic       ut, redir, ms;

  logic pcw_a, ifw_a, iff_a, idw_a, idf_a, emf_a, busy_a, done_a;
  logic pcw_b, ifw_b, iff_b, idw_b, idf_b, emf_b, busy_b, done_b;
  logic [CW_A-1:0] sc_a;
  logic [CW_B-1:0] sc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: cycles of MULTI left for the op in EX (incl. current), and stall totals.
  int rem_a = 0, rem_b = 0;
  int cnt_a = 0, cnt_b = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULTI_LATENCY(LAT_A), .CNT_W(CW_A)) dut_a (
    .Clk(clk), .Reset(rst), .MemReadExecute(mr), .WriteRegExecute(wr),
    .RsDecode(rs), .RtDecode(rt), .UsesRtDecode(ut), .RedirectExecute(redir),
    .MultiStartExecute(ms), .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(iff_a),
    .IDEXWrite(idw_a), .IDEXFlush(idf_a), .EXMEMFlush(emf_a), .MultiBusy(busy_a),
    .MultiDone(done_a), .StallCount(sc_a)
  );

  hazard_stall_controller #(.MULTI_LATENCY(LAT_B), .CNT_W(CW_B)) dut_b (
    .Clk(clk), .Reset(rst), .MemReadExecute(mr), .WriteRegExecute(wr),
    .RsDecode(rs), .RtDecode(rt), .UsesRtDecode(ut), .RedirectExecute(redir),
    .MultiStartExecute(ms), .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(iff_b),
    .IDEXWrite(idw_b), .IDEXFlush(idf_b), .EXMEMFlush(emf_b), .MultiBusy(busy_b),
    .MultiDone(done_b), .StallCount(sc_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit order: PCWrite IFIDWrite IFIDFlush IDEXWrite IDEXFlush EXMEMFlush MultiBusy MultiDone
  function automatic logic [7:0] model_outs(input int rem);
    bit lu;
    lu = (mr != 0) && (wr != 0) && ((wr == rs) || (ut && (wr == rt)));
    if (rst)          return 8'b0000_0000;
    if (rem > 1)      return 8'b0000_0110;
    if (rem == 1)     return 8'b1101_0011;
    if (redir)        return 8'b1111_1000;
    if (ms)           return 8'b0000_0100;
    if (lu)           return 8'b0001_1000;
    return 8'b1101_0000;
  endfunction

  task automatic model_step(inout int rem, inout int cnt, input int lat, input int cw);
    logic [7:0] e;
    e = model_outs(rem);
    if (!e[7] && (cnt < (1 << cw) - 1)) cnt++;
    if (rem > 0)          rem--;
    else if (!redir && ms) rem = lat - 1;
  endtask

  task automatic check_all();
    if (rst) begin
      rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    end
    check_val("outs_a", 32'({pcw_a, ifw_a, iff_a, idw_a, idf_a, emf_a, busy_a, done_a}),
              32'(model_outs(rem_a)));
    check_val("outs_b", 32'({pcw_b, ifw_b, iff_b, idw_b, idf_b, emf_b, busy_b, done_b}),
              32'(model_outs(rem_b)));
    check_val("stall_cnt_a", 32'(sc_a), 32'(cnt_a));
    check_val("stall_cnt_b", 32'(sc_b), 32'(cnt_b));
  endtask

  // Inputs are set just after a falling edge; check, advance one rising edge, return at the next falling edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (rst) begin
      rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    end else begin
      model_step(rem_a, cnt_a, LAT_A, CW_A);
      model_step(rem_b, cnt_b, LAT_B, CW_B);
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic [1:0] m, input logic [4:0] w, input logic [4:0] s,
                        input logic [4:0] t, input logic u, input logic r, input logic x);
    mr = m; wr = w; rs = s; rt = t; ut = u; redir = r; ms = x;
  endtask

  initial begin
    int sc0;
    rst = 1'b1;
    set_in(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    #1;
    check_val("idle_pcwrite", 32'(pcw_a), 32'd1);
    check_val("idle_sc", 32'(sc_a), 32'd0);

    // Load-use on rs, then cleared: one stall cycle only.
    set_in(2'b01, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("lu_pcwrite", 32'(pcw_a), 32'd0);
    check_val("lu_idexflush", 32'(idf_a), 32'd1);
    step();
    set_in(2'b00, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    set_in(2'b01, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_in(2'b01, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    step();
    set_in(2'b10, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
    step();

    // Redirect overrides a load-use match.
    sc0 = int'(sc_a);
    set_in(2'b01, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);
    #1;
    check_val("redir_pcwrite", 32'(pcw_a), 32'd1);
    step();
    check_val("redir_sc", 32'(sc_a), 32'(sc0));

    // Multi-cycle op with start held for the full latency.
    sc0 = int'(sc_a);
    set_in(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < LAT_A; i++) step();
    set_in(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("multi_sc_delta", 32'(int'(sc_a) - sc0), 32'd3);
    check_val("multi_back_run", 32'(busy_a), 32'd0);
    step();

    // Reset pulse in the second MULTI cycle.
    ms = 1'b1;
    step();
    ms = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_val("rst_mid_pcwrite", 32'(pcw_a), 32'd0);
    check_val("rst_mid_sc", 32'(sc_a), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Saturation: 20 back-to-back ops on the 4-bit instance.
    ms = 1'b1;
    for (int i = 0; i < 2 * 20; i++) step();
    check_val("sat_sc_b", 32'(sc_b), 32'd15);
    ms = 1'b0;
    step();

    // Randomized traffic with biased register matches.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      mr    = 2'($urandom_range(0, 3));
      wr    = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      ut    = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 7) == 0);
      ms    = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
